// File: rtl/ex_div_unit_pkg.sv
// rtl/ex_div_unit_pkg.sv - shared encodings for the EX-stage divider
// Purpose: state encodings and handshake/reset level constants used by
//          ex_div_unit and its bench. No ports.
package ex_div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic RstEnable         = 1'b1;

endpackage

// File: rtl/ex_div_unit_if.sv
// rtl/ex_div_unit_if.sv - request/result bundle between EX stage and divider
// Purpose: groups the divider request and result signals.
// Ports (modport master = EX stage, slave = divider):
//   signed_div_i, opdata1_i, opdata2_i, start_i, annul_i : EX -> divider
//   result_o {remainder, quotient}, ready_o             : divider -> EX
interface ex_div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/ex_div_unit_div_step.sv
// rtl/ex_div_unit_div_step.sv - one combinational restoring-division iteration
// Purpose: shifts the next dividend bit into the partial remainder, trial
//          subtracts the divisor and produces the quotient bit.
// Ports:
//   rem           in  current partial remainder (always < divisor)
//   dividend      in  dividend/quotient shift register, next bit at MSB
//   divisor       in  divisor magnitude
//   rem_next      out updated partial remainder
//   dividend_next out shift register with the new quotient bit at LSB
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] dividend_next
);
  logic [DATA_W:0] partial;
  logic [DATA_W:0] diff;
  logic            borrow;

  assign partial = {rem, dividend[DATA_W-1]};
  assign diff    = partial - {1'b0, divisor};
  // partial < 2*divisor, so the top bit of the DATA_W+1-bit difference is the borrow.
  assign borrow  = diff[DATA_W];

  assign rem_next      = borrow ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
  assign dividend_next = {dividend[DATA_W-2:0], ~borrow};
endmodule

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
// Purpose: DATA_W-iteration divider beside the EX-stage ALU; result goes to
//          HI (remainder) and LO (quotient).
// Ports:
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-high reset
//   div_if     slave modport: operands, start/annul in; result_o/ready_o out
// Optional build macro: DIV_ZERO_DIVIDEND_FAST_EN (zero dividend finishes
//   straight from FREE to END).
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic clk,
  input  logic rst,
  ex_div_unit_if.slave div_if
);
  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   step_rem;
  logic [DATA_W-1:0]   step_dvd;
  logic                op1_neg;
  logic                op2_neg;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem           (rem_q),
    .dividend      (dvd_q),
    .divisor       (dvs_q),
    .rem_next      (step_rem),
    .dividend_next (step_dvd)
  );

  assign op1_neg = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
  assign op2_neg = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (div_if.start_i == DivStart && !div_if.annul_i) begin
          if (div_if.opdata2_i == '0) begin
            state_d = DivByZero;
`ifdef DIV_ZERO_DIVIDEND_FAST_EN
          end else if (div_if.opdata1_i == '0) begin
            state_d = DivEnd;
            ready_d = DivResultReady;
`endif
          end else begin
            state_d    = DivOn;
            cnt_d      = '0;
            rem_d      = '0;
            // Iterate on magnitudes; signs are restored on the final edge.
            dvd_d      = op1_neg ? -div_if.opdata1_i : div_if.opdata1_i;
            dvs_d      = op2_neg ? -div_if.opdata2_i : div_if.opdata2_i;
            neg_quot_d = op1_neg ^ op2_neg;
            neg_rem_d  = op1_neg;
          end
        end
      end

      DivByZero: begin
        if (div_if.annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end

      DivOn: begin
        if (div_if.annul_i) begin
          state_d = DivFree;
        end else begin
          rem_d = step_rem;
          dvd_d = step_dvd;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = DivEnd;
            ready_d  = DivResultReady;
            result_d = {neg_rem_q  ? -step_rem : step_rem,
                        neg_quot_q ? -step_dvd : step_dvd};
          end
        end
      end

      DivEnd: begin
        if (div_if.annul_i || div_if.start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - self-checking bench for ex_div_unit
module tb_ex_div_unit;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_div_unit_if #(.DATA_W(DATA_W)) dif ();

  ex_div_unit #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic: SV division truncates toward zero and the
  // remainder takes the dividend's sign, which is exactly DIV semantics.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Edges from the start-capturing edge (inclusive) to the edge raising ready.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 2;
`ifdef DIV_ZERO_DIVIDEND_FAST_EN
    if (a == 0) return 1;
`endif
    return DATA_W + 1;
  endfunction

  // Transaction-level model: one request in flight, its result due m_lat edges
  // after it was accepted, released when start drops or annul arrives.
  bit          m_busy = 1'b0;
  int          m_edges = 0;
  int          m_lat = 0;
  logic [63:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (dif.start_i && !dif.annul_i) begin
        m_busy  = 1'b1;
        m_edges = 1;
        m_lat   = ref_lat(dif.opdata1_i, dif.opdata2_i);
        m_res   = ref_div(dif.signed_div_i, dif.opdata1_i, dif.opdata2_i);
      end
    end else begin
      if (dif.annul_i || (m_edges >= m_lat && !dif.start_i)) m_busy = 1'b0;
      else if (m_edges < m_lat) m_edges++;
    end
  end

  always @(negedge clk) begin
    logic exp_ready;
    exp_ready = m_busy && (m_edges >= m_lat);
    check("cycle", {dif.ready_o, dif.result_o}, {exp_ready, exp_ready ? m_res : 64'd0});
  end

  task automatic idle();
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issues one request, waits (bounded) for ready, holds, then drops start.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit scramble,
                        output logic [63:0] got, output int lat);
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.annul_i      = 1'b0;
    dif.start_i      = 1'b1;
    lat = 0;
    got = '0;
    forever begin
      step();
      lat++;
      if (scramble) begin
        dif.opdata1_i    = $urandom;
        dif.opdata2_i    = $urandom;
        dif.signed_div_i = 1'($urandom);
      end
      if (dif.ready_o) break;
      if (lat > 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout: ready_o still 0 after %0d cycles, required by %0d", lat, ref_lat(a, b));
        break;
      end
    end
    got = dif.result_o;
    repeat (hold) step();
    dif.start_i = 1'b0;
    step();
  endtask

  initial begin
    logic [63:0] got;
    int          lat;
    bit          saw_ready;
    logic [31:0] a, b;
    bit          sgn;

    idle();
    rst = 1'b1;
    step();
    step();
    check("reset_outputs", {dif.ready_o, dif.result_o}, 65'd0);
    rst = 1'b0;
    step();

    run_op(1'b0, 32'd100, 32'd7, 3, 1'b0, got, lat);
    check("divu_100_7", {1'b0, got}, {1'b0, 32'd2, 32'd14});
    check("divu_100_7_lat", 65'(lat), 65'd33);
    check("divu_100_7_release", {dif.ready_o, dif.result_o}, 65'd0);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, got, lat);
    check("div_m7_2", {1'b0, got}, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});

    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1, 1'b0, got, lat);
    check("div_7_m2", {1'b0, got}, {1'b0, 32'd1, 32'hFFFF_FFFD});

    run_op(1'b0, 32'd5, 32'd0, 1, 1'b0, got, lat);
    check("divu_by_zero", {1'b0, got}, 65'd0);
    check("divu_by_zero_lat", 65'(lat), 65'd2);

    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 0, 1'b0, got, lat);
    check("div_by_zero_lat", 65'(lat), 65'd2);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, got, lat);
    check("div_overflow", {1'b0, got}, {1'b0, 32'd0, 32'h8000_0000});

    run_op(1'b0, 32'd0, 32'd5, 0, 1'b0, got, lat);
    check("zero_dividend", {1'b0, got}, 65'd0);
`ifdef DIV_ZERO_DIVIDEND_FAST_EN
    check("zero_dividend_lat", 65'(lat), 65'd1);
`else
    check("zero_dividend_lat", 65'(lat), 65'd33);
`endif

    // Annul partway through the iterations; no result may ever appear.
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    repeat (10) step();
    dif.start_i = 1'b0;
    dif.annul_i = 1'b1;
    step();
    dif.annul_i = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      step();
      if (dif.ready_o) saw_ready = 1'b1;
    end
    check("annul_no_ready", 65'(saw_ready), 65'd0);

    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 0, 1'b0, got, lat);
    check("divu_after_annul", {1'b0, got}, {1'b0, 32'h0000_000F, 32'h0FFF_FFFF});

    // Asynchronous reset between edges, first mid-iteration, then while ready.
    dif.opdata1_i = 32'd12345;
    dif.opdata2_i = 32'd67;
    dif.start_i   = 1'b1;
    repeat (5) step();
    #1 rst = 1'b1;
    #1 check("async_rst_mid_on", {dif.ready_o, dif.result_o}, 65'd0);
    step();
    rst = 1'b0;
    step();
    lat = 0;
    while (!dif.ready_o && lat < 100) begin
      step();
      lat++;
    end
    check("ready_before_end_rst", 65'(dif.ready_o), 65'd1);
    #1 rst = 1'b1;
    #1 check("async_rst_in_end", {dif.ready_o, dif.result_o}, 65'd0);
    dif.start_i = 1'b0;
    step();
    rst = 1'b0;
    step();

    run_op(1'b0, 32'd12345, 32'd67, 0, 1'b0, got, lat);
    check("after_rst", {1'b0, got}, {1'b0, 32'd17, 32'd184});
    check("after_rst_lat", 65'(lat), 65'd33);

    for (int i = 0; i < 60; i++) begin
      sgn = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a = 32'd0;
        1:       a = 32'h8000_0000;
        2:       a = $urandom_range(0, 255);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op(sgn, a, b, $urandom_range(0, 3), 1'($urandom), got, lat);
      check("rand_result", {1'b0, got}, {1'b0, ref_div(sgn, a, b)});
      check("rand_lat", 65'(lat), 65'(ref_lat(a, b)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
